ball_motion: RTL and testbench

Frame-rate projectile engine for the basketball shot: holds the ball at a start position, launches on a `shoot` pulse with operator-supplied velocity, and integrates gravity once per video frame. It sits directly upstream of the pixel generator and drives its `ball_x`/`ball_y` inputs, replacing the constant coordinates. It reports a made or missed shot.

---
 rtl/ball_motion_if.sv | 22 ++
 rtl/ball_motion.sv | 172 +++++++++++++++++
 tb/tb_ball_motion.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// Control and position bundle between the shot controller and the ball motion engine.
interface ball_motion_if;
    logic       frame_tick;
    logic       shoot;
    logic [7:0] vx0;
    logic [7:0] vy0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_flight;
    logic       made;
    logic       missed;

    modport master (
        output frame_tick, shoot, vx0, vy0,
        input  ball_x, ball_y, in_flight, made, missed
    );

    modport slave (
        input  frame_tick, shoot, vx0, vy0,
        output ball_x, ball_y, in_flight, made, missed
    );
endinterface

// File: rtl/ball_motion.sv
// Frame-rate projectile engine: holds the ball, launches on shoot, integrates gravity per frame
// in Q10.4 position / Q8.4 velocity, and reports a made or missed shot.
module ball_motion #(
    parameter int START_X     = 10,
    parameter int START_Y     = 300,
    parameter int GRAVITY     = 4,
    parameter int HOOP_Y      = 150,
    parameter int HOOP_X_MIN  = 540,
    parameter int HOOP_X_MAX  = 580,
    parameter int FLOOR_Y     = 470,
    parameter int X_MAX       = 630,
    parameter int HOLD_FRAMES = 60
) (
    input  logic          clk,
    input  logic          reset_n,
    ball_motion_if.slave  bus
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [13:0]        START_X_FP = 14'(START_X * 16);
    localparam logic [13:0]        START_Y_FP = 14'(START_Y * 16);
    localparam logic [13:0]        HOOP_Y_U   = 14'(HOOP_Y * 16);
    localparam logic signed [15:0] HOOP_Y_S   = 16'(HOOP_Y * 16);
    localparam logic [13:0]        FLOOR_Y_U  = 14'(FLOOR_Y * 16);
    localparam logic signed [15:0] FLOOR_Y_S  = 16'(FLOOR_Y * 16);
    localparam logic [13:0]        X_MAX_FP   = 14'(X_MAX * 16);
    localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_r,  state_s;
    logic [13:0]        x_fp_r,   x_fp_s;
    logic [13:0]        y_fp_r,   y_fp_s;
    logic [11:0]        vx_r,     vx_s;
    logic signed [11:0] vy_r,     vy_s;
    logic [HW-1:0]      hold_r,   hold_s;
    logic               made_r,   made_s;
    logic               missed_r, missed_s;
    logic               in_flight_r;

    logic signed [15:0] y_sum_s;
    logic [13:0]        x_sum_s;
    logic signed [12:0] vy_grav_s;
    logic signed [11:0] vy_sat_s;
    logic               ceil_s, floor_s, right_s, hit_s;

    // Candidate next position/velocity; y is widened and signed so a ceiling crossing shows as negative
    assign y_sum_s   = $signed({2'b00, y_fp_r}) + $signed({{4{vy_r[11]}}, vy_r});
    assign x_sum_s   = x_fp_r + {2'b00, vx_r};
    assign vy_grav_s = $signed({vy_r[11], vy_r}) + $signed(13'(GRAVITY));
    assign vy_sat_s  = (vy_grav_s > 13'sd2047) ? 12'sd2047 : vy_grav_s[11:0];

    assign ceil_s  = (y_sum_s < 16'sd0);
    assign floor_s = (y_sum_s >= FLOOR_Y_S);
    assign right_s = (x_sum_s >= X_MAX_FP);
    assign hit_s   = (vy_r > 12'sd0) && (y_fp_r < HOOP_Y_U) && (y_sum_s >= HOOP_Y_S) &&
                     (x_sum_s[13:4] >= 10'(HOOP_X_MIN)) && (x_sum_s[13:4] <= 10'(HOOP_X_MAX));

    // Next-state and datapath decode
    always_comb begin
        state_s  = state_r;
        x_fp_s   = x_fp_r;
        y_fp_s   = y_fp_r;
        vx_s     = vx_r;
        vy_s     = vy_r;
        hold_s   = hold_r;
        made_s   = 1'b0;
        missed_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                x_fp_s = START_X_FP;
                y_fp_s = START_Y_FP;
                hold_s = {HW{1'b0}};
                if (bus.shoot) begin
                    state_s = ST_FLIGHT;
                    vx_s    = {4'b0000, bus.vx0};
                    vy_s    = 12'sd0 - $signed({4'b0000, bus.vy0});
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLIGHT: begin
                if (bus.frame_tick) begin
                    // Ceiling contact kills the upward speed and skips gravity for that frame
                    if (ceil_s) begin
                        y_fp_s = 14'd0;
                        vy_s   = 12'sd0;
                    end else if (floor_s) begin
                        y_fp_s = FLOOR_Y_U;
                        vy_s   = vy_sat_s;
                    end else begin
                        y_fp_s = y_sum_s[13:0];
                        vy_s   = vy_sat_s;
                    end
                    if (right_s) begin
                        x_fp_s = X_MAX_FP;
                    end else begin
                        x_fp_s = x_sum_s;
                    end
                    if (hit_s) begin
                        made_s  = 1'b1;
                        state_s = ST_DONE;
                    end else if (floor_s || right_s) begin
                        missed_s = 1'b1;
                        state_s  = ST_DONE;
                    end else begin
                        state_s = ST_FLIGHT;
                    end
                end else begin
                    state_s = ST_FLIGHT;
                end
            end
            ST_DONE: begin
                if (bus.frame_tick) begin
                    if (hold_r == HOLD_LAST) begin
                        state_s = ST_IDLE;
                        hold_s  = {HW{1'b0}};
                        x_fp_s  = START_X_FP;
                        y_fp_s  = START_Y_FP;
                    end else begin
                        hold_s = hold_r + HW'(1);
                    end
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                x_fp_s  = START_X_FP;
                y_fp_s  = START_Y_FP;
                hold_s  = {HW{1'b0}};
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            x_fp_r      <= START_X_FP;
            y_fp_r      <= START_Y_FP;
            vx_r        <= 12'd0;
            vy_r        <= 12'sd0;
            hold_r      <= {HW{1'b0}};
            made_r      <= 1'b0;
            missed_r    <= 1'b0;
            in_flight_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_fp_r      <= x_fp_s;
            y_fp_r      <= y_fp_s;
            vx_r        <= vx_s;
            vy_r        <= vy_s;
            hold_r      <= hold_s;
            made_r      <= made_s;
            missed_r    <= missed_s;
            in_flight_r <= (state_s == ST_FLIGHT);
        end
    end

    assign bus.ball_x    = x_fp_r[13:4];
    assign bus.ball_y    = y_fp_r[13:4];
    assign bus.in_flight = in_flight_r;
    assign bus.made      = made_r;
    assign bus.missed    = missed_r;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: three parameterisations share one stimulus stream.
module tb_ball_motion;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       reset_n;
    logic       shoot_v [3];
    logic       tick_v  [3];
    logic [7:0] vx0_v   [3];
    logic [7:0] vy0_v   [3];
    logic [9:0] ax [3];
    logic [9:0] ay [3];
    logic       afl [3];
    logic       amd [3];
    logic       ams [3];

    ball_motion_if bus_a ();
    ball_motion_if bus_b ();
    ball_motion_if bus_c ();

    assign bus_a.shoot = shoot_v[0];  assign bus_a.frame_tick = tick_v[0];
    assign bus_a.vx0   = vx0_v[0];    assign bus_a.vy0        = vy0_v[0];
    assign bus_b.shoot = shoot_v[1];  assign bus_b.frame_tick = tick_v[1];
    assign bus_b.vx0   = vx0_v[1];    assign bus_b.vy0        = vy0_v[1];
    assign bus_c.shoot = shoot_v[2];  assign bus_c.frame_tick = tick_v[2];
    assign bus_c.vx0   = vx0_v[2];    assign bus_c.vy0        = vy0_v[2];

    assign ax[0] = bus_a.ball_x; assign ay[0] = bus_a.ball_y; assign afl[0] = bus_a.in_flight;
    assign amd[0] = bus_a.made;  assign ams[0] = bus_a.missed;
    assign ax[1] = bus_b.ball_x; assign ay[1] = bus_b.ball_y; assign afl[1] = bus_b.in_flight;
    assign amd[1] = bus_b.made;  assign ams[1] = bus_b.missed;
    assign ax[2] = bus_c.ball_x; assign ay[2] = bus_c.ball_y; assign afl[2] = bus_c.in_flight;
    assign amd[2] = bus_c.made;  assign ams[2] = bus_c.missed;

    ball_motion u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    ball_motion #(.START_Y(10)) u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.slave));
    ball_motion #(.START_X(560), .START_Y(100)) u_c (.clk(clk), .reset_n(reset_n), .bus(bus_c.slave));

    localparam int GRAV = 4, HOOP_Y = 150, HXMIN = 540, HXMAX = 580;
    localparam int FLOOR = 470, XMAX = 630, HOLD = 60;
    int p_sx [3] = '{10, 10, 560};
    int p_sy [3] = '{300, 10, 100};

    // Reference model: mode 0 = waiting, 1 = in the air, 2 = showing the result
    int m_mode [3], m_x [3], m_y [3], m_vx [3], m_vy [3], m_hold [3];
    bit m_made [3], m_miss [3];

    typedef logic [22:0] obs_t;   // {ball_x, ball_y, in_flight, made, missed}
    obs_t q0 [$], q1 [$], q2 [$];
    obs_t mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t model_obs(int k);
        return {10'(m_x[k] / 16), 10'(m_y[k] / 16), (m_mode[k] == 1), m_made[k], m_miss[k]};
    endfunction

    task automatic model_step(int k, bit rst, bit sh, bit tk);
        int yn, xn;
        bit hit, fl, rt;
        m_made[k] = 1'b0;
        m_miss[k] = 1'b0;
        if (rst) begin
            m_mode[k] = 0; m_x[k] = p_sx[k] * 16; m_y[k] = p_sy[k] * 16;
            m_vx[k] = 0; m_vy[k] = 0; m_hold[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (sh) begin
                m_mode[k] = 1;
                m_vx[k]   = int'(vx0_v[k]);
                m_vy[k]   = -int'(vy0_v[k]);
            end
        end else if (m_mode[k] == 1) begin
            if (tk) begin
                yn  = m_y[k] + m_vy[k];
                xn  = m_x[k] + m_vx[k];
                hit = (m_vy[k] > 0) && (m_y[k] < HOOP_Y * 16) && (yn >= HOOP_Y * 16) &&
                      (xn / 16 >= HXMIN) && (xn / 16 <= HXMAX);
                fl  = (yn >= FLOOR * 16);
                rt  = (xn >= XMAX * 16);
                if (yn < 0) begin
                    m_y[k] = 0; m_vy[k] = 0;
                end else begin
                    m_y[k]  = fl ? FLOOR * 16 : yn;
                    m_vy[k] = (m_vy[k] + GRAV > 2047) ? 2047 : m_vy[k] + GRAV;
                end
                m_x[k] = rt ? XMAX * 16 : xn;
                if (hit) begin
                    m_made[k] = 1'b1; m_mode[k] = 2;
                end else if (fl || rt) begin
                    m_miss[k] = 1'b1; m_mode[k] = 2;
                end
            end
        end else begin
            if (tk) begin
                m_hold[k]++;
                if (m_hold[k] == HOLD) begin
                    m_mode[k] = 0; m_hold[k] = 0;
                    m_x[k] = p_sx[k] * 16; m_y[k] = p_sy[k] * 16;
                end
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_obs(string name, obs_t act, obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d fl=%b md=%b ms=%b expected x=%0d y=%0d fl=%b md=%b ms=%b",
                     name, $time, act[22:13], act[12:3], act[2], act[1], act[0],
                     exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict, queue the expectation
    task automatic cycle(bit rst, bit [2:0] sh, bit [2:0] tk);
        @(negedge clk);
        reset_n = !rst;
        for (int k = 0; k < 3; k++) begin
            shoot_v[k] = sh[k];
            tick_v[k]  = tk[k];
            model_step(k, rst, sh[k], tk[k]);
        end
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        q2.push_back(model_obs(2));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every registered output update is compared against the oldest prediction
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            mon_e = q0.pop_front();
            cmp_obs("dut_a", {ax[0], ay[0], afl[0], amd[0], ams[0]}, mon_e);
        end
        if (q1.size() > 0) begin
            mon_e = q1.pop_front();
            cmp_obs("dut_b", {ax[1], ay[1], afl[1], amd[1], ams[1]}, mon_e);
        end
        if (q2.size() > 0) begin
            mon_e = q2.pop_front();
            cmp_obs("dut_c", {ax[2], ay[2], afl[2], amd[2], ams[2]}, mon_e);
        end
    end

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            shoot_v[k] = 1'b0; tick_v[k] = 1'b0; vx0_v[k] = 8'd0; vy0_v[k] = 8'd0;
        end

        // Reset with shoot and frame_tick held high
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b111, 3'b111);
        check("reset_x", int'(ax[0]), 10);
        check("reset_y", int'(ay[0]), 300);
        check("reset_flight", int'(afl[0]), 0);

        // Launch coincident with a frame tick: launch only, no motion
        vx0_v[0] = 8'd32; vy0_v[0] = 8'd0;
        vx0_v[1] = 8'd0;  vy0_v[1] = 8'd255;
        vx0_v[2] = 8'd0;  vy0_v[2] = 8'd0;
        cycle(1'b0, 3'b111, 3'b111);
        check("coinc_x", int'(ax[0]), 10);
        check("coinc_y", int'(ay[0]), 300);
        check("coinc_flight", int'(afl[0]), 1);
        check("coinc_c_y", int'(ay[2]), 100);

        for (int t = 1; t <= 140; t++) begin
            if (t == 2) vx0_v[0] = 8'd200;
            cycle(1'b0, (t == 2) ? 3'b111 : 3'b000, 3'b111);
            if (t == 1) check("ceil_y_t1", int'(ay[1]), 0);
            if (t == 2) check("ceil_y_t2", int'(ay[1]), 0);
            if (t == 4) begin
                check("drop_x_t4", int'(ax[0]), 18);
                check("drop_y_t4", int'(ay[0]), 301);
            end
            if (t == 20) begin
                check("made_y_t20", int'(ay[2]), 147);
                check("made_pulse_t20", int'(amd[2]), 0);
            end
            if (t == 21) begin
                check("made_pulse_t21", int'(amd[2]), 1);
                check("made_y_t21", int'(ay[2]), 152);
                check("made_no_miss", int'(ams[2]), 0);
                check("made_flight_low", int'(afl[2]), 0);
            end
            cycle(1'b0, 3'b000, 3'b000);
            cycle(1'b0, 3'b000, 3'b000);
        end
        check("rearm_b_y", int'(ay[1]), 10);

        // Long flat shot to the floor, hold, re-arm
        vx0_v[0] = 8'd255; vy0_v[0] = 8'd0;
        cycle(1'b0, 3'b001, 3'b000);
        check("miss_launch", int'(afl[0]), 1);
        for (int t = 1; t <= 98; t++) begin
            cycle(1'b0, 3'b000, 3'b001);
            if (t == 37) check("miss_y_t37", int'(ay[0]), 466);
            if (t == 38) begin
                check("miss_pulse", int'(ams[0]), 1);
                check("miss_no_made", int'(amd[0]), 0);
                check("miss_x", int'(ax[0]), 615);
                check("miss_y", int'(ay[0]), 470);
            end
            if (t == 97) check("hold_x_t97", int'(ax[0]), 615);
            if (t == 98) begin
                check("rearm_x", int'(ax[0]), 10);
                check("rearm_y", int'(ay[0]), 300);
            end
            cycle(1'b0, 3'b000, 3'b000);
        end
        cycle(1'b0, 3'b001, 3'b000);
        check("rearm_shoot", int'(afl[0]), 1);

        // Randomised traffic with one reset in the middle
        for (int i = 0; i < 6000; i++) begin
            bit [2:0] sh, tk;
            for (int k = 0; k < 3; k++) begin
                sh[k]    = ($urandom_range(0, 15) == 0);
                tk[k]    = ($urandom_range(0, 2) == 0);
                vx0_v[k] = 8'($urandom_range(0, 255));
                vy0_v[k] = 8'($urandom_range(0, 255));
            end
            cycle((i == 3000) || (i == 3001), sh, tk);
        end

        cycle(1'b0, 3'b000, 3'b000);
        cycle(1'b0, 3'b000, 3'b000);
        @(posedge clk);
        #2;
        check("queue_drain", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
